// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_timer_pkg;

    localparam int unsigned DEF_OUTPUT_WIDTH   = 16;
    localparam int unsigned DEF_IDATA_WIDTH    = 16;
    localparam int unsigned DEF_PRESCALE_WIDTH = 8;

    // state | meaning
    // IDLE  | count held, waiting for start
    // RUN   | counting down at the prescaled tick rate
    // DONE  | one-shot finished, count is 0
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Load data is zero-extended into the count, so it must not be wider.
    function automatic bit widths_ok(input int unsigned idata_w, input int unsigned out_w);
        return (idata_w > 0) && (idata_w <= out_w);
    endfunction

endpackage

// File: rtl/countdown_timer_ip_prescaler.sv
// Prescaler: emits a tick every prescale_i+1 enabled cycles.
module countdown_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      tick_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

    // Tick on match; a counter already past a lowered prescale wraps through all-ones.
    always_comb begin
        tick_o = enable_i && (cnt_q == prescale_i);
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_timer_ip.sv
// Loadable down-counter with one-shot or auto-reload expiry pulse.
module countdown_timer_ip
    import countdown_timer_pkg::*;
#(
    parameter int unsigned OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
    parameter int unsigned IDATA_WIDTH    = DEF_IDATA_WIDTH,
    parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      load_i,
    input  logic                      start_i,
    input  logic                      enable_i,
    input  logic                      periodic_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic [IDATA_WIDTH-1:0]    data_in_i,
    output logic [OUTPUT_WIDTH-1:0]   count_o,
    output logic                      expired_o,
    output logic                      busy_o
);

    if (!widths_ok(IDATA_WIDTH, OUTPUT_WIDTH)) begin : g_width_check
        $error("countdown_timer_ip: IDATA_WIDTH must be <= OUTPUT_WIDTH");
    end

    state_e                  state_q, state_d;
    logic [OUTPUT_WIDTH-1:0] count_q, count_d;
    logic [OUTPUT_WIDTH-1:0] reload_q, reload_d;
    logic                    expired_q, expired_d;
    logic                    presc_clear;
    logic                    presc_en;
    logic                    tick;
    logic                    start_ok;

    assign presc_en = enable_i && (state_q == RUN);

    countdown_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (presc_clear),
        .enable_i  (presc_en),
        .prescale_i(prescale_i),
        .tick_o    (tick)
    );

    // Next-state logic; priority is load, then start, then tick.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        expired_d   = 1'b0;
        presc_clear = 1'b0;
        start_ok    = start_i && (((state_q == IDLE) && (count_q != '0)) ||
                                  ((state_q == DONE) && (reload_q != '0)));
        if (load_i) begin
            count_d     = OUTPUT_WIDTH'(data_in_i);
            reload_d    = OUTPUT_WIDTH'(data_in_i);
            state_d     = IDLE;
            presc_clear = 1'b1;
        end else if (start_ok) begin
            if (state_q == DONE) count_d = reload_q;
            state_d     = RUN;
            presc_clear = 1'b1;
        end else if ((state_q == RUN) && tick) begin
            if (count_q > OUTPUT_WIDTH'(1)) begin
                count_d = count_q - OUTPUT_WIDTH'(1);
            end else begin
                expired_d = 1'b1;
                if (periodic_i) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
        end
    end

    // State, count, reload and expiry pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = expired_q;
    assign busy_o    = (state_q == RUN);

endmodule
